// File: rtl/lut_sweep_pkg.sv
// rtl/lut_sweep_pkg.sv - shared state type and sizing helpers for the LUT sweep engine
package lut_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    // A channel must hold the full count 2^n_in, hence one extra bit.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int row_lsb(input int row, input int n_out);
        return row * n_out;
    endfunction

endpackage

// File: rtl/lut_table_mem.sv
// rtl/lut_table_mem.sv - truth-table storage, one write port, registered lookup and sweep read ports (LUT_RESET_INIT_EN)
module lut_table_mem #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] INIT = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [N_IN-1:0]  wr_addr_i,
    input  logic [N_OUT-1:0] wr_data_i,
    input  logic [N_IN-1:0]  lk_addr_i,
    output logic [N_OUT-1:0] lk_data_o,
    input  logic             sw_en_i,
    input  logic [N_IN-1:0]  sw_addr_i,
    output logic [N_OUT-1:0] sw_data_o
);
    import lut_sweep_pkg::*;

    localparam int DEPTH = 2**N_IN;
`ifdef LUT_RESET_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam logic [DEPTH*N_OUT-1:0] RESET_IMAGE = INIT_EN ? INIT : '0;

    logic [N_OUT-1:0] mem_q [DEPTH];
    logic [N_OUT-1:0] lk_q;
    logic [N_OUT-1:0] sw_q;

    // Lookup reads old data on a collision; the sweep port forwards the
    // write so a sweep started alongside a write sees the new row.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= RESET_IMAGE[row_lsb(r, N_OUT) +: N_OUT];
            end
            lk_q <= '0;
            sw_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            lk_q <= mem_q[lk_addr_i];
            if (sw_en_i) begin
                sw_q <= (wr_en_i && (wr_addr_i == sw_addr_i)) ? wr_data_i : mem_q[sw_addr_i];
            end
        end
    end

    assign lk_data_o = lk_q;
    assign sw_data_o = sw_q;

endmodule

// File: rtl/lut_sweep_engine.sv
// rtl/lut_sweep_engine.sv - programmable truth table with exhaustive sweep sequencer (LUT_RESET_INIT_EN selects INIT reset image)
module lut_sweep_engine #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] INIT = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       prog_valid_i,
    output logic                       prog_ready_o,
    input  logic [N_IN-1:0]            prog_addr_i,
    input  logic [N_OUT-1:0]           prog_data_i,
    input  logic [N_IN-1:0]            x_i,
    output logic [N_OUT-1:0]           y_o,
    input  logic                       sweep_start_i,
    output logic                       sweep_busy_o,
    output logic                       sweep_valid_o,
    output logic [N_IN-1:0]            sweep_x_o,
    output logic [N_OUT-1:0]           sweep_y_o,
    output logic                       sweep_done_o,
    output logic [N_OUT*(N_IN+1)-1:0]  ones_cnt_o
);
    import lut_sweep_pkg::*;

    localparam int CW = cnt_width(N_IN);
    localparam logic [N_IN-1:0] LAST_ROW = '1;

    sweep_state_e           state_q;
    logic                   prog_ready_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   done_q;
    logic [N_IN-1:0]        sx_q;
    logic [N_OUT*CW-1:0]    ones_q;

    logic                   wr_en;
    logic                   start_acc;
    logic                   sw_en;
    logic [N_IN-1:0]        sw_addr;
    logic [N_OUT-1:0]       sw_data;

    assign wr_en     = prog_valid_i && prog_ready_q;
    assign start_acc = sweep_start_i && (state_q == ST_IDLE);
    // Fetch one row ahead so the row shown in each cycle matches sweep_x.
    assign sw_en     = start_acc || ((state_q == ST_SWEEP) && (sx_q != LAST_ROW));
    assign sw_addr   = (state_q == ST_SWEEP) ? sx_q + 1'b1 : '0;

    lut_table_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .INIT  (INIT)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_addr_i (prog_addr_i),
        .wr_data_i (prog_data_i),
        .lk_addr_i (x_i),
        .lk_data_o (y_o),
        .sw_en_i   (sw_en),
        .sw_addr_i (sw_addr),
        .sw_data_o (sw_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            prog_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            sx_q         <= '0;
            ones_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (sweep_start_i) begin
                        state_q      <= ST_SWEEP;
                        prog_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        valid_q      <= 1'b1;
                        sx_q         <= '0;
                        ones_q       <= '0;
                    end
                end
                ST_SWEEP: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        ones_q[k*CW +: CW] <= ones_q[k*CW +: CW] + CW'(sw_data[k]);
                    end
                    if (sx_q == LAST_ROW) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        sx_q <= sx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    prog_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign prog_ready_o  = prog_ready_q;
    assign sweep_busy_o  = busy_q;
    assign sweep_valid_o = valid_q;
    assign sweep_x_o     = sx_q;
    assign sweep_y_o     = sw_data;
    assign sweep_done_o  = done_q;
    assign ones_cnt_o    = ones_q;

endmodule

// File: tb/tb_lut_sweep_engine.sv
// tb/tb_lut_sweep_engine.sv - randomized self-checking bench for lut_sweep_engine (LUT_RESET_INIT_EN aware)
module tb_lut_sweep_engine;

    localparam logic [15:0] INIT1 = 16'h0AC5;
`ifdef LUT_RESET_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       pv = 1'b0, pr, ss = 1'b0, sb, sv, sd, pd = 1'b0, y, sy;
    logic [3:0] pa = '0, x = '0, sx;
    logic [4:0] oc;

    logic       pv2 = 1'b0, pr2, ss2 = 1'b0, sb2, sv2, sd2;
    logic [2:0] pa2 = '0, x2 = '0, sx2;
    logic [1:0] pd2 = '0, y2, sy2;
    logic [7:0] oc2;

    int checks = 0;
    int errors = 0;
    logic       m1 [16];
    logic [1:0] m2 [8];

    lut_sweep_engine #(.N_IN(4), .N_OUT(1), .INIT(INIT1)) dut (
        .clk_i(clk), .rst_i(rst), .prog_valid_i(pv), .prog_ready_o(pr),
        .prog_addr_i(pa), .prog_data_i(pd), .x_i(x), .y_o(y),
        .sweep_start_i(ss), .sweep_busy_o(sb), .sweep_valid_o(sv),
        .sweep_x_o(sx), .sweep_y_o(sy), .sweep_done_o(sd), .ones_cnt_o(oc)
    );

    lut_sweep_engine #(.N_IN(3), .N_OUT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .prog_valid_i(pv2), .prog_ready_o(pr2),
        .prog_addr_i(pa2), .prog_data_i(pd2), .x_i(x2), .y_o(y2),
        .sweep_start_i(ss2), .sweep_busy_o(sb2), .sweep_valid_o(sv2),
        .sweep_x_o(sx2), .sweep_y_o(sy2), .sweep_done_o(sd2), .ones_cnt_o(oc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        logic [15:0] img;
        img = INIT1;
        for (int r = 0; r < 16; r++) m1[r] = INIT_ON ? img[r] : 1'b0;
        for (int r = 0; r < 8; r++) m2[r] = 2'b00;
    endtask

    task automatic write1(input logic [3:0] a, input logic d);
        pv = 1'b1; pa = a; pd = d;
        tick();
        pv = 1'b0;
        m1[a] = d;
    endtask

    task automatic write2(input logic [2:0] a, input logic [1:0] d);
        pv2 = 1'b1; pa2 = a; pd2 = d;
        tick();
        pv2 = 1'b0;
        m2[a] = d;
    endtask

    // Starts a sweep on dut and records what it reports; any pending
    // prog_valid rides along with the start cycle only.
    task automatic cap1(output logic [15:0] ys, output int nrows, output int xerr,
                        output int dcyc, output logic [4:0] ones);
        ys = '0; nrows = 0; xerr = 0; dcyc = -1; ones = '0;
        ss = 1'b1;
        tick();
        ss = 1'b0; pv = 1'b0;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            if (sv === 1'b1) begin
                if (sx !== nrows[3:0] || sb !== 1'b1 || pr !== 1'b0) xerr++;
                ys[sx] = sy;
                nrows++;
            end
            if (sd === 1'b1) begin
                dcyc = c;
                ones = oc;
            end
            if (dcyc < 0) tick();
        end
    endtask

    task automatic cap2(output logic [15:0] ys, output int nrows, output int xerr,
                        output int dcyc, output logic [7:0] ones);
        ys = '0; nrows = 0; xerr = 0; dcyc = -1; ones = '0;
        ss2 = 1'b1;
        tick();
        ss2 = 1'b0;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            if (sv2 === 1'b1) begin
                if (sx2 !== nrows[2:0] || sb2 !== 1'b1) xerr++;
                ys[sx2*2 +: 2] = sy2;
                nrows++;
            end
            if (sd2 === 1'b1) begin
                dcyc = c;
                ones = oc2;
            end
            if (dcyc < 0) tick();
        end
    endtask

    task automatic sweep1_expect(input string tag);
        logic [15:0] ys, exp_ys;
        int nrows, xerr, dcyc, cnt;
        logic [4:0] ones;
        cnt = 0;
        for (int r = 0; r < 16; r++) begin
            exp_ys[r] = m1[r];
            cnt += int'(m1[r]);
        end
        cap1(ys, nrows, xerr, dcyc, ones);
        checks++;
        if (ys !== exp_ys || nrows != 16 || xerr != 0) begin
            errors++;
            $display("FAIL %s rows: got %h (n=%0d seq_err=%0d) want %h (n=16 seq_err=0)", tag, ys, nrows, xerr, exp_ys);
        end
        checks++;
        if (dcyc != 17 || ones !== 5'(cnt)) begin
            errors++;
            $display("FAIL %s done: cycle %0d ones %0d, want cycle 17 ones %0d", tag, dcyc, ones, cnt);
        end
        tick();
        checks++;
        if (sb !== 1'b0 || pr !== 1'b1 || sd !== 1'b0 || oc !== 5'(cnt)) begin
            errors++;
            $display("FAIL %s idle: busy=%b ready=%b done=%b ones=%0d, want 0 1 0 %0d", tag, sb, pr, sd, oc, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        checks++;
        if ({y, sv, sx, sy, sd, sb, oc, pr} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset dut: y=%b v=%b x=%0d sy=%b d=%b b=%b ones=%0d rdy=%b, want all 0 and rdy=1", y, sv, sx, sy, sd, sb, oc, pr);
        end
        checks++;
        if ({y2, sv2, sx2, sy2, sd2, sb2, oc2, pr2} !== {2'b0, 1'b0, 3'd0, 2'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset dut2: y=%b v=%b x=%0d sy=%b d=%b b=%b ones=%h rdy=%b, want all 0 and rdy=1", y2, sv2, sx2, sy2, sd2, sb2, oc2, pr2);
        end
    endtask

    task automatic test_lookup();
        logic [3:0] a;
        logic old_v;
        x = 4'b1001; tick();
        checks++;
        if (y !== m1[9]) begin errors++; $display("FAIL lookup x=9: y=%b want %b", y, m1[9]); end
        x = 4'b0100; tick();
        checks++;
        if (y !== m1[4]) begin errors++; $display("FAIL lookup x=4: y=%b want %b", y, m1[4]); end
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(15));
            x = a; tick();
            checks++;
            if (y !== m1[a]) begin errors++; $display("FAIL lookup rand x=%0d: y=%b want %b", a, y, m1[a]); end
        end
        a = 4'($urandom_range(15));
        old_v = m1[a];
        x = a;
        write1(a, ~old_v);
        checks++;
        if (y !== old_v) begin errors++; $display("FAIL lookup collision old x=%0d: y=%b want %b", a, y, old_v); end
        tick();
        checks++;
        if (y !== ~old_v) begin errors++; $display("FAIL lookup collision new x=%0d: y=%b want %b", a, y, ~old_v); end
    endtask

    task automatic test_random_program();
        for (int i = 0; i < 24; i++) write1(4'($urandom_range(15)), 1'($urandom_range(1)));
        sweep1_expect("rand_table");
    endtask

    task automatic test_write_with_start();
        pv = 1'b1; pa = 4'd15; pd = ~m1[15];
        m1[15] = ~m1[15];
        sweep1_expect("wr_start_row15");
        pv = 1'b1; pa = 4'd0; pd = ~m1[0];
        m1[0] = ~m1[0];
        sweep1_expect("wr_start_row0");
    endtask

    task automatic test_busy_block();
        int blocked, ndone;
        logic [3:0] a;
        logic d;
        a = 4'($urandom_range(15));
        d = ~m1[a];
        blocked = 0; ndone = 0;
        ss = 1'b1; tick(); ss = 1'b0;
        pv = 1'b1; pa = a; pd = d;
        for (int c = 0; c < 40; c++) begin
            if (sd === 1'b1) ndone++;
            if (pr === 1'b1) break;
            blocked++;
            ss = (c == 5);
            tick();
        end
        ss = 1'b0;
        tick();
        pv = 1'b0;
        m1[a] = d;
        checks++;
        if (blocked != 17) begin errors++; $display("FAIL busy ready_low_cycles: got %0d want 17", blocked); end
        x = a; tick();
        checks++;
        if (y !== d) begin errors++; $display("FAIL busy held_write row %0d: y=%b want %b", a, y, d); end
        for (int c = 0; c < 20; c++) begin
            if (sd === 1'b1) ndone++;
            if (sb === 1'b1) ndone += 100;
            tick();
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL busy done_pulses: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_mid_sweep();
        int extra;
        for (int i = 0; i < 16; i++) write1(4'(i), 1'($urandom_range(1)));
        ss = 1'b1; tick(); ss = 1'b0;
        for (int c = 0; c < 30 && !(sv === 1'b1 && sx === 4'd7); c++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        checks++;
        if ({y, sv, sx, sy, sd, sb, oc, pr} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL midreset: y=%b v=%b x=%0d sy=%b d=%b b=%b ones=%0d rdy=%b, want all 0 and rdy=1", y, sv, sx, sy, sd, sb, oc, pr);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            if (sd !== 1'b0 || sb !== 1'b0 || sv !== 1'b0) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL midreset activity_after_abort: got %0d cycles want 0", extra); end
        sweep1_expect("midreset_reinit");
    endtask

    task automatic test_wide();
        logic [15:0] ys, exp_ys;
        int nrows, xerr, dcyc, c0, c1;
        logic [7:0] ones;
        for (int i = 0; i < 8; i++) write2(3'(i), 2'b11);
        cap2(ys, nrows, xerr, dcyc, ones);
        checks++;
        if (ys !== 16'hFFFF || nrows != 8 || xerr != 0 || dcyc != 9 || ones !== {4'd8, 4'd8}) begin
            errors++;
            $display("FAIL wide all_ones: rows %h n=%0d seq_err=%0d done %0d ones %h, want ffff 8 0 9 88", ys, nrows, xerr, dcyc, ones);
        end
        tick();
        for (int i = 0; i < 8; i++) write2(3'(i), 2'($urandom_range(3)));
        c0 = 0; c1 = 0; exp_ys = '0;
        for (int r = 0; r < 8; r++) begin
            exp_ys[r*2 +: 2] = m2[r];
            c0 += int'(m2[r][0]);
            c1 += int'(m2[r][1]);
        end
        cap2(ys, nrows, xerr, dcyc, ones);
        checks++;
        if (ys !== exp_ys || nrows != 8 || xerr != 0 || dcyc != 9 || ones !== {4'(c1), 4'(c0)}) begin
            errors++;
            $display("FAIL wide random: rows %h n=%0d seq_err=%0d done %0d ones %h, want %h 8 0 9 %h", ys, nrows, xerr, dcyc, ones, exp_ys, {4'(c1), 4'(c0)});
        end
        tick();
    endtask

    initial begin
        test_reset();
        sweep1_expect("reset_image");
        test_lookup();
        test_random_program();
        test_write_with_start();
        test_busy_block();
        test_reset_mid_sweep();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_sweep_engine.md
# lut_sweep_engine

Programmable N-input, multi-output truth-table block with an autonomous exhaustive-sweep sequencer. It holds a writable lookup table, answers registered point lookups, and on command walks every input combination 0..2^N_IN-1, streaming each row and accumulating a per-output ones count. It sits beside the gate-, primitive-, and UDP-level implementations of the same functions and serves as the hardware golden model and self-check source.

## Interface
- N_IN, 4, table input width (2..8); table depth is 2^N_IN rows
- N_OUT, 1, output channels per row (1..8)
- INIT, 0, reset table image, 2^N_IN*N_OUT bits, row r at bits [r*N_OUT +: N_OUT]; used only under the configuration macro
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- prog_valid  in  1  row write request
- prog_ready  out  1  write accepted when high; high only in IDLE
- prog_addr  in  N_IN  row to write
- prog_data  in  N_OUT  row contents
- x  in  N_IN  point-lookup address
- y  out  N_OUT  registered lookup result
- sweep_start  in  1  begin sweep; accepted only in IDLE
- sweep_busy  out  1  high in SWEEP and DONE
- sweep_valid  out  1  sweep_x/sweep_y carry a row
- sweep_x  out  N_IN  row index being reported
- sweep_y  out  N_OUT  table contents of that row
- sweep_done  out  1  one-cycle pulse after last row
- ones_cnt  out  N_OUT*(N_IN+1)  per-output count of 1s over the sweep, channel k at [k*(N_IN+1) +: N_IN+1]

## Operation
- States: IDLE, SWEEP, DONE. IDLE -> SWEEP on sweep_start; SWEEP -> DONE when index = 2^N_IN-1 is issued; DONE -> IDLE unconditionally after one cycle.
- Write: prog_valid & prog_ready commits prog_data to row prog_addr at that edge. Writes in SWEEP/DONE are not accepted (prog_ready=0); the requester holds prog_valid.
- Lookup: y registers table[x] every cycle in every state; read-before-write on same-edge collision (old data).
- Sweep: index counter starts at 0 and increments by 1 per cycle, no stalls; counter width N_IN, terminal at all-ones, no wrap emitted.
- ones_cnt cleared at sweep_start acceptance; each reported row adds sweep_y[k] to channel k; width N_IN+1 holds full count 2^N_IN without overflow. Value held from DONE until next accepted sweep_start.
- sweep_start during SWEEP/DONE ignored, not queued.
- prog write and sweep_start in the same IDLE cycle: both accepted; sweep observes the new row.
- Reset (any state, including mid-sweep): state IDLE, abort sweep, y=0, sweep_valid=0, sweep_x=0, sweep_y=0, sweep_done=0, sweep_busy=0, ones_cnt=0, prog_ready=1 in the following cycle; table cleared to 0 (or INIT, see Configuration).

## Timing
- Lookup latency 1 cycle: x at edge E -> y valid after E.
- sweep_start accepted at edge E0: row r reported with sweep_valid=1 in cycle after E0+r, r = 0..2^N_IN-1 (2^N_IN consecutive cycles).
- sweep_done pulses the cycle after the last row; ones_cnt final in that same cycle.
- Total start-to-done: 2^N_IN+1 cycles; earliest next sweep_start accepted the cycle after sweep_done.

## Configuration
- LUT_RESET_INIT_EN defined: reset loads table from INIT.
- Undefined: reset clears table to all zeros; INIT ignored.

## Structure
- Package lut_sweep_pkg: state enum (IDLE, SWEEP, DONE), count-width helper function (N_IN+1), row-slice helper.
- Sub-module lut_table_mem: 2^N_IN x N_OUT storage, one synchronous write port, two registered read ports (lookup, sweep), reset/INIT load. Sequencer and counters stay in the top.

## Test plan
- LUT_RESET_INIT_EN, N_IN=4, N_OUT=1, INIT=16'h0AC5; reset, sweep -> rows 0..15 report 1,0,1,0,0,0,1,1,0,1,0,1,0,0,0,0; sweep_done on cycle 17; ones_cnt=6.
- Same image, x=4'b1001 then 4'b0100 -> y=1 then 0, each one cycle after x.
- Without macro: reset, sweep -> all rows 0, ones_cnt=0; write row 15=1 with sweep_start same cycle -> row 15 reports 1, ones_cnt=1.
- prog_valid held during SWEEP -> prog_ready=0 for 17 cycles, write lands in first IDLE cycle; sweep_start mid-sweep ignored (one sweep_done only).
- rst asserted at sweep row 7 -> next cycle all outputs 0, IDLE, no sweep_done; table reinitialised.
- N_IN=3, N_OUT=2, all rows 2'b11 -> 8 rows, ones_cnt={4'd8,4'd8}, done at cycle 9.
